uart_rx: RTL
============

# uart_rx

- UART receiver: 8-N-1 asynchronous serial in, parallel byte out.
- Pairs with the team's UART transmitter on the same line format: start bit 0, 8 data bits LSB first, stop bit 1, same `CLKS_PER_BIT` divisor.
- Sits between the board RX pin and the CPU-side MMIO/UART register block.
- Delivers each received byte with a one-cycle valid pulse and flags framing errors.

## Interface
- `CLKS_PER_BIT`, default 868: clocks per bit period (100 MHz / 115200 baud). Must be ≥ 8.
- `clk` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_in` in 1: serial line, asynchronous to `clk`, idles high.
- `rx_data` out 8: last correctly received byte.
- `rx_valid` out 1: one-cycle pulse; `rx_data` is new this cycle.
- `rx_busy` out 1: high while a frame is being received.
- `rx_frame_err` out 1: one-cycle pulse; stop bit sampled as 0.

## Operation
- **Input synchronizer**
  - `rx_in` passes through a 2-flop synchronizer; both flops reset to 1.
  - All decisions use the synchronized value `rx_s`.
- **Counters**
  - Clock counter is ≥ $clog2(`CLKS_PER_BIT`) bits wide; 10 bits at the default value.
  - Bit counter is 3 bits.
- **State machine**
  - **IDLE**
    - `rx_busy` = 0.
    - A 1→0 transition on `rx_s` clears the counter and moves to START.
  - **START**
    - Counts to `CLKS_PER_BIT/2 - 1` (integer division), then samples `rx_s`.
    - Sample 1 (false start/glitch): return to IDLE. No outputs pulse.
    - Sample 0: clear the counter and the bit counter, then go to DATA.
  - **DATA**
    - Samples when the counter reaches `CLKS_PER_BIT - 1`, i.e. bit centres.
    - Each sample is written into shift register bit [bit counter], so LSB is received first.
    - After bit 7, clear the counter and go to STOP.
  - **STOP**
    - Samples at `CLKS_PER_BIT - 1`.
    - Sample 1: `rx_data` ← shift register, `rx_valid` pulses, go to IDLE.
    - Sample 0: `rx_frame_err` pulses, `rx_data` is unchanged, go to WAIT_HIGH.
  - **WAIT_HIGH**
    - Stays until `rx_s` = 1, then goes to IDLE.
    - This prevents a break condition from being decoded as repeated frames.
- `rx_busy` = 1 in START, DATA, STOP and WAIT_HIGH.
- There is no receive buffer and no backpressure. A consumer that misses the `rx_valid` pulse loses the byte.
- `rx_data` holds its value until the next valid frame.

## Timing
- **Reset values:** `rx_data` = 0x00, `rx_valid` = 0, `rx_busy` = 0, `rx_frame_err` = 0, state = IDLE, synchronizer = 1.
- **Start detection:** a falling edge on `rx_in` enters START 3 clocks later (2 synchronizer flops + edge detect register).
- **Frame completion:**
  - `rx_valid` / `rx_frame_err` are registered and assert 1 clock after the stop-bit sample, for exactly 1 clock.
  - IDLE is entered in the same cycle.
- **Back-to-back frames:**
  - A start edge arriving in the stop-sample cycle or later is accepted.
  - Frame duration is about 9.5 bit periods, which tolerates roughly ±4% clock mismatch.
- **Reset mid-frame:** all outputs return to reset values immediately. The partial byte is discarded and never reported.
- **Line at 0 after reset:** no edge is seen, so the block stays in IDLE.

## Configuration
- **Macro:** `UART_RX_MAJORITY_EN`.
- **Defined:**
  - Keep a 3-bit history of `rx_s`.
  - Every sample point (START, DATA, STOP) uses the 2-of-3 majority of the value at the sample cycle and the two preceding cycles.
  - A single-cycle glitch at bit centre is rejected.
- **Undefined:** single sample of `rx_s` at the sample cycle, with no history register.
- Timing of state transitions and output pulses is identical in both builds.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.

- **Single byte:** send 0xA5 8-N-1. Expect one `rx_valid` pulse with `rx_data` = 0xA5 and `rx_busy` high for the frame. `rx_frame_err` stays 0.
- **Back-to-back bytes:** send 0x00, 0xFF, 0x55 with no idle gap. Expect three `rx_valid` pulses and data 0x00, 0xFF, 0x55 in order.
- **False start:** drive `rx_in` low for 4 clocks, then high. Expect return to IDLE and no `rx_valid`/`rx_frame_err`. A following 0x3C is received correctly.
- **Framing error:** send 0x81 with stop bit = 0, holding the line low for 3 further bit times. Expect one `rx_frame_err` pulse and no `rx_valid`. `rx_data` keeps its prior value and `rx_busy` stays high until the line rises. The next 0x42 is received.
- **Reset mid-frame:** assert `reset_n` low during data bit 3, release, then send 0x7E. Expect all outputs 0 during reset, no pulse for the aborted frame, and then 0x7E.
- **Majority vote:** inject a 1-clock inverted glitch at the centre of data bit 2 while sending 0x00.
  - With `UART_RX_MAJORITY_EN` defined: `rx_data` = 0x00.
  - Without it: `rx_data` = 0x04.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status pulses out.
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;

  modport master (
    input  rx_in,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output rx_frame_err
  );

  modport slave (
    output rx_in,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  rx_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 receiver; START entered 3 clks after rx_in falls, byte/error pulse 1 clk after stop sample.
// No backpressure: a missed rx_valid loses the byte. Define UART_RX_MAJORITY_EN for 2-of-3 voting at sample points.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    warm;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          sample;
  logic          fall;

  // rx_prev only arms once real line data has reached rx_s, so a line held
  // low through reset is not mistaken for a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      warm    <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= bus.rx_in;
      rx_s    <= rx_meta;
      warm    <= {warm[0], 1'b1};
      rx_prev <= warm[1] ? rx_s : 1'b0;
    end
  end

  assign fall = rx_prev & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_hist <= 2'b11;
    else          rx_hist <= {rx_hist[0], rx_s};
  end

  assign sample = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      bit_cnt          <= 3'd0;
      shift            <= 8'h00;
      bus.rx_data      <= 8'h00;
      bus.rx_valid     <= 1'b0;
      bus.rx_busy      <= 1'b0;
      bus.rx_frame_err <= 1'b0;
    end else begin
      bus.rx_valid     <= 1'b0;
      bus.rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state       <= START;
            cnt         <= '0;
            bus.rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt     <= '0;
            bit_cnt <= 3'd0;
            if (sample) begin
              state       <= IDLE;
              bus.rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            shift[bit_cnt] <= sample;
            cnt            <= '0;
            if (bit_cnt == 3'd7) state <= STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (sample) begin
              bus.rx_data  <= shift;
              bus.rx_valid <= 1'b1;
              // A start edge landing on the stop sample is taken immediately.
              if (fall) begin
                state <= START;
              end else begin
                state       <= IDLE;
                bus.rx_busy <= 1'b0;
              end
            end else begin
              bus.rx_frame_err <= 1'b1;
              state            <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state       <= IDLE;
            bus.rx_busy <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          bus.rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
